// File: rtl/hazard_stall_ctrl_if.sv
// Signals between the ID/EX/MEM pipeline and the hazard scheduler.
// The pipeline side is master; the scheduler is slave.
interface hazard_stall_ctrl_if #(
   parameter int WIDTH_T = 2
);
   logic               rs_used_ID;
   logic               rt_used_ID;
   logic [4:0]         addrRs_ID;
   logic [4:0]         addrRt_ID;
   logic [WIDTH_T-1:0] Tuse_rs_ID;
   logic [WIDTH_T-1:0] Tuse_rt_ID;
   logic [4:0]         regWriteAddr_EX;
   logic [WIDTH_T-1:0] Tnew_EX;
   logic [4:0]         regWriteAddr_MEM;
   logic [WIDTH_T-1:0] Tnew_MEM;
   logic               md_use_ID;
   logic               md_start_EX;
   logic               md_is_div_EX;
   logic               stall;
   logic               clr_EX;
   logic               md_busy;
   logic               md_done;
   logic               md_err;
   logic [31:0]        stall_cnt;

   modport master (
      output rs_used_ID, rt_used_ID, addrRs_ID, addrRt_ID, Tuse_rs_ID, Tuse_rt_ID,
             regWriteAddr_EX, Tnew_EX, regWriteAddr_MEM, Tnew_MEM,
             md_use_ID, md_start_EX, md_is_div_EX,
      input  stall, clr_EX, md_busy, md_done, md_err, stall_cnt
   );

   modport slave (
      input  rs_used_ID, rt_used_ID, addrRs_ID, addrRt_ID, Tuse_rs_ID, Tuse_rt_ID,
             regWriteAddr_EX, Tnew_EX, regWriteAddr_MEM, Tnew_MEM,
             md_use_ID, md_start_EX, md_is_div_EX,
      output stall, clr_EX, md_busy, md_done, md_err, stall_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Tuse/Tnew hazard scheduler for the 5-stage MIPS core: stalls IF/ID, bubbles ID/EX,
// and sequences the shared multi-cycle HI/LO multiply/divide unit.
module hazard_stall_ctrl #(
   parameter int WIDTH_T  = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int CNT_W    = 4
) (
   input  logic               clk,
   input  logic               reset,
   hazard_stall_ctrl_if.slave bus
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_e;

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   md_state_e        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             md_done_q, md_done_nxt;
   logic             md_err_q, md_err_nxt;
   logic [31:0]      stall_cnt_q;
   logic             stall_rs, stall_rt, stall_md, stall;

   // An operand stalls when its producer's result arrives later than the operand is consumed.
   function automatic logic operand_stall(
      input logic               used,
      input logic [4:0]         addr,
      input logic [WIDTH_T-1:0] tuse,
      input logic [4:0]         ex_addr,
      input logic [WIDTH_T-1:0] ex_tnew,
      input logic [4:0]         mem_addr,
      input logic [WIDTH_T-1:0] mem_tnew
   );
      return used && (addr != 5'd0) &&
             (((addr == ex_addr)  && (ex_tnew  > tuse)) ||
              ((addr == mem_addr) && (mem_tnew > tuse)));
   endfunction

   assign stall_rs = operand_stall(bus.rs_used_ID, bus.addrRs_ID, bus.Tuse_rs_ID,
                                   bus.regWriteAddr_EX, bus.Tnew_EX,
                                   bus.regWriteAddr_MEM, bus.Tnew_MEM);
   assign stall_rt = operand_stall(bus.rt_used_ID, bus.addrRt_ID, bus.Tuse_rt_ID,
                                   bus.regWriteAddr_EX, bus.Tnew_EX,
                                   bus.regWriteAddr_MEM, bus.Tnew_MEM);
   // A launch in EX already claims the unit this cycle, before md_busy rises.
   assign stall_md = bus.md_use_ID && ((state == BUSY) || bus.md_start_EX);
   assign stall    = stall_rs | stall_rt | stall_md;

   assign bus.stall     = stall;
   assign bus.clr_EX    = stall;
   assign bus.md_busy   = (state == BUSY);
   assign bus.md_done   = md_done_q;
   assign bus.md_err    = md_err_q;
   assign bus.stall_cnt = stall_cnt_q;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt   = state;
      cnt_nxt     = cnt;
      md_done_nxt = 1'b0;
      md_err_nxt  = md_err_q;
      unique case (state)
         IDLE: begin
            if (bus.md_start_EX) begin
               cnt_nxt   = bus.md_is_div_EX ? DIV_LOAD : MULT_LOAD;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (bus.md_start_EX) md_err_nxt = 1'b1;
            if (cnt == CNT_ONE) begin
               state_nxt   = IDLE;
               cnt_nxt     = '0;
               md_done_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         md_done_q   <= 1'b0;
         md_err_q    <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         md_done_q <= md_done_nxt;
         md_err_q  <= md_err_nxt;
         if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the hazard rules and the multiply/divide unit.
module tb_hazard_stall_ctrl;

   localparam int WIDTH_T  = 2;
   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 10;
   localparam int CNT_W    = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.WIDTH_T(WIDTH_T)) bus ();

   hazard_stall_ctrl #(
      .WIDTH_T (WIDTH_T),
      .MULT_LAT(MULT_LAT),
      .DIV_LAT (DIV_LAT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: cycles the unit stays busy, pending done pulse, sticky error, stall tally.
   int          m_left = 0;
   bit          m_done = 1'b0;
   bit          m_err  = 1'b0;
   logic [31:0] m_cnt  = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit operand_waits(input bit used, input logic [4:0] a, input logic [WIDTH_T-1:0] tuse);
      int need;
      need = int'(tuse);
      if (!used || a == 5'd0) return 1'b0;
      if (a == bus.regWriteAddr_EX && int'(bus.Tnew_EX) > need) return 1'b1;
      if (a == bus.regWriteAddr_MEM && int'(bus.Tnew_MEM) > need) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit exp_stall();
      return operand_waits(bus.rs_used_ID, bus.addrRs_ID, bus.Tuse_rs_ID) ||
             operand_waits(bus.rt_used_ID, bus.addrRt_ID, bus.Tuse_rt_ID) ||
             (bus.md_use_ID && (m_left > 0 || bus.md_start_EX));
   endfunction

   task automatic check_outputs(input string tag);
      bit s;
      s = exp_stall();
      check({tag, "_stall"},     bus.stall,     s);
      check({tag, "_clr"},       bus.clr_EX,    s);
      check({tag, "_busy"},      bus.md_busy,   m_left > 0);
      check({tag, "_done"},      bus.md_done,   m_done);
      check({tag, "_err"},       bus.md_err,    m_err);
      check({tag, "_stall_cnt"}, bus.stall_cnt, m_cnt);
   endtask

   task automatic model_tick();
      bit s;
      bit fin;
      s   = exp_stall();
      fin = 1'b0;
      if (!reset) begin
         m_left = 0; m_done = 1'b0; m_err = 1'b0; m_cnt = '0;
         return;
      end
      if (s && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_left > 0) begin
         if (bus.md_start_EX) m_err = 1'b1;
         m_left--;
         fin = (m_left == 0);
      end else if (bus.md_start_EX) begin
         m_left = bus.md_is_div_EX ? DIV_LAT : MULT_LAT;
      end
      m_done = fin;
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic cycle(input string tag);
      #1;
      check_outputs(tag);
      @(posedge clk);
      model_tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.rs_used_ID = 1'b0; bus.rt_used_ID = 1'b0;
      bus.addrRs_ID = '0; bus.addrRt_ID = '0;
      bus.Tuse_rs_ID = '0; bus.Tuse_rt_ID = '0;
      bus.regWriteAddr_EX = '0; bus.Tnew_EX = '0;
      bus.regWriteAddr_MEM = '0; bus.Tnew_MEM = '0;
      bus.md_use_ID = 1'b0; bus.md_start_EX = 1'b0; bus.md_is_div_EX = 1'b0;
   endtask

   task automatic drive_random();
      bus.rs_used_ID       = 1'($urandom_range(0, 1));
      bus.rt_used_ID       = 1'($urandom_range(0, 1));
      bus.addrRs_ID        = 5'($urandom_range(0, 3));
      bus.addrRt_ID        = 5'($urandom_range(0, 3));
      bus.Tuse_rs_ID       = WIDTH_T'($urandom_range(0, 3));
      bus.Tuse_rt_ID       = WIDTH_T'($urandom_range(0, 3));
      bus.regWriteAddr_EX  = 5'($urandom_range(0, 3));
      bus.Tnew_EX          = WIDTH_T'($urandom_range(0, 3));
      bus.regWriteAddr_MEM = 5'($urandom_range(0, 3));
      bus.Tnew_MEM         = WIDTH_T'($urandom_range(0, 3));
      bus.md_use_ID        = ($urandom_range(0, 2) == 0);
      bus.md_start_EX      = ($urandom_range(0, 7) == 0);
      bus.md_is_div_EX     = 1'($urandom_range(0, 1));
   endtask

   initial begin
      int stalls, dones, busy_n, done_at;
      bit got;

      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      #1;
      check("reset_busy", bus.md_busy, 1'b0);
      check("reset_cnt", bus.stall_cnt, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cycle("idle");

      // Load-use on rs through EX.
      bus.rs_used_ID = 1'b1; bus.addrRs_ID = 5'd5; bus.Tuse_rs_ID = 2'd1;
      bus.regWriteAddr_EX = 5'd5; bus.Tnew_EX = 2'd2;
      #1;
      check("lu_stall", bus.stall, 1'b1);
      check("lu_clr", bus.clr_EX, 1'b1);
      cycle("lu0");
      bus.Tnew_EX = 2'd1;
      #1;
      check("lu_release", bus.stall, 1'b0);
      check("lu_cnt", bus.stall_cnt, 32'd1);
      cycle("lu1");

      // Register $0 never stalls; mismatched addresses never stall.
      bus.addrRs_ID = 5'd0; bus.regWriteAddr_EX = 5'd0; bus.Tnew_EX = 2'd2;
      #1;
      check("zero_reg", bus.stall, 1'b0);
      cycle("zero");
      bus.addrRs_ID = 5'd7; bus.regWriteAddr_EX = 5'd8; bus.regWriteAddr_MEM = 5'd9; bus.Tnew_MEM = 2'd3;
      #1;
      check("no_match", bus.stall, 1'b0);
      cycle("nomatch");
      idle_inputs();

      // mult followed by mfhi waiting in ID.
      bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b0; bus.md_use_ID = 1'b1;
      stalls = 0; dones = 0; busy_n = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) bus.md_start_EX = 1'b0;
         #1;
         stalls += int'(bus.stall);
         dones  += int'(bus.md_done);
         busy_n += int'(bus.md_busy);
         cycle("mult");
      end
      check("mult_stalls", stalls, 6);
      check("mult_dones", dones, 1);
      check("mult_busy", busy_n, MULT_LAT);
      idle_inputs();

      // div, then a second div launched in the done cycle.
      bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b1;
      cycle("div0");
      got = 1'b0; done_at = -1;
      for (int i = 0; i < 20; i++) begin
         bus.md_start_EX = 1'b0;
         #1;
         if (bus.md_done) begin
            bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b1;
            got = 1'b1; done_at = i;
         end
         cycle("div_wait");
         if (got) break;
      end
      check("b2b_done_seen", got, 1'b1);
      check("b2b_done_at", done_at, DIV_LAT);
      bus.md_start_EX = 1'b0;
      busy_n = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         busy_n += int'(bus.md_busy);
         cycle("div_b2b");
      end
      check("b2b_busy", busy_n, DIV_LAT);
      check("b2b_err", bus.md_err, 1'b0);

      // Illegal start while a mult is at count 3.
      bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b0;
      cycle("ill0");
      bus.md_start_EX = 1'b0;
      cycle("ill1");
      cycle("ill2");
      bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b1;
      busy_n = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         busy_n += int'(bus.md_busy);
         cycle("ill");
         bus.md_start_EX = 1'b0;
      end
      check("ill_busy_left", busy_n, 3);
      check("ill_err", bus.md_err, 1'b1);
      cycle("ill_hold");
      check("ill_err_sticky", bus.md_err, 1'b1);

      // Asynchronous reset in the middle of a div.
      bus.md_start_EX = 1'b1; bus.md_is_div_EX = 1'b1;
      cycle("ar0");
      bus.md_start_EX = 1'b0;
      cycle("ar1");
      cycle("ar2");
      bus.md_use_ID = 1'b1;
      #1;
      check("ar_pre_stall", bus.stall, 1'b1);
      #1;
      reset = 1'b0;
      #1;
      m_left = 0; m_done = 1'b0; m_err = 1'b0; m_cnt = '0;
      check("ar_busy", bus.md_busy, 1'b0);
      check("ar_err", bus.md_err, 1'b0);
      check("ar_cnt", bus.stall_cnt, 32'd0);
      check("ar_stall", bus.stall, 1'b0);
      @(negedge clk);
      cycle("ar_hold");
      reset = 1'b1;
      bus.md_use_ID = 1'b0;
      dones = 0;
      for (int i = 0; i < 14; i++) begin
         #1;
         dones += int'(bus.md_done);
         cycle("ar_after");
      end
      check("ar_no_done", dones, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         drive_random();
         cycle("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline hazard scheduler for the 5-stage MIPS core; sits beside the ID stage.
- Decides stall of PC/IF-ID and bubble-insert (clr) of ID/EX from Tuse/Tnew register dependencies.
- Owns the sequencing of the shared multi-cycle HI/LO multiply/divide unit: start, busy countdown, done.
- Stalls any ID-stage HI/LO instruction while that unit is occupied.

Parameters:
- WIDTH_T, 2, width of Tuse/Tnew fields.
- MULT_LAT, 5, busy cycles for mult/multu (>=1).
- DIV_LAT, 10, busy cycles for div/divu (>=1).
- CNT_W, 4, width of the busy counter; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rs_used_ID  in  1  ID instruction reads rs.
- rt_used_ID  in  1  ID instruction reads rt.
- addrRs_ID  in  5  rs address in ID.
- addrRt_ID  in  5  rt address in ID.
- Tuse_rs_ID  in  WIDTH_T  cycles until rs is consumed.
- Tuse_rt_ID  in  WIDTH_T  cycles until rt is consumed.
- regWriteAddr_EX  in  5  destination register of the EX instruction (0 = none).
- Tnew_EX  in  WIDTH_T  cycles until the EX result is ready.
- regWriteAddr_MEM  in  5  destination register of the MEM instruction.
- Tnew_MEM  in  WIDTH_T  cycles until the MEM result is ready.
- md_use_ID  in  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
- md_start_EX  in  1  EX instruction launches mult/div this cycle.
- md_is_div_EX  in  1  the launched operation is a divide.
- stall  out  1  freeze PC and the IF/ID register.
- clr_EX  out  1  bubble into the ID/EX register (equals stall).
- md_busy  out  1  multiply/divide unit occupied.
- md_done  out  1  one-cycle pulse when the HI/LO result is valid.
- md_err  out  1  sticky flag: md_start_EX was seen while busy.
- stall_cnt  out  32  saturating count of stalled cycles.

Behaviour:
- Reset (reset==0, async): state IDLE, busy counter 0, md_done 0, md_err 0, stall_cnt 0. Combinational outputs follow from these values, so md_busy=0 during reset.
- Data hazard, combinational:
  - stall_rs = rs_used_ID && addrRs_ID!=0 && ((addrRs_ID==regWriteAddr_EX && Tnew_EX>Tuse_rs_ID) || (addrRs_ID==regWriteAddr_MEM && Tnew_MEM>Tuse_rs_ID)).
  - stall_rt is the same check on the rt fields.
  - Comparisons are unsigned.
  - A match in EX takes priority conceptually, but any stalling match stalls.
- MD hazard, combinational: stall_md = md_use_ID && (md_busy || md_start_EX).
- stall = stall_rs | stall_rt | stall_md. clr_EX = stall. No register is inserted, so there is zero-cycle latency.
- MD FSM states:
  - IDLE: on md_start_EX, load counter with DIV_LAT if md_is_div_EX else MULT_LAT, then go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter==1, the next state is IDLE, the counter becomes 0, and md_done=1 for exactly that following cycle.
  - md_busy = (state==BUSY).
- Simultaneous events:
  - md_done cycle with md_start_EX: a new operation is accepted immediately (back-to-back). md_done still pulses.
  - md_start_EX in BUSY: ignored, counter unaffected, md_err set (sticky until reset).
- Counter width: the loaded latency is truncated to CNT_W bits, so the parameter rule must hold.
- stall_cnt increments on every rising edge with stall==1 and saturates at 32'hFFFFFFFF (no wrap).
- Reset asserted mid-operation: FSM aborts to IDLE at once, no md_done pulse is issued, and stall drops once the inputs allow.

Test Plan:
1. Load-use: EX writes $5 with Tnew_EX=2, ID reads rs=$5 with Tuse_rs=1 -> stall=clr_EX=1. Next cycle with Tnew_EX=1 -> stall=0. stall_cnt=1.
2. Register $0 and no-match: regWriteAddr_EX=0 with addrRs_ID=0 and Tnew=2, or addresses differ -> stall=0.
3. Mult then mfhi: md_start_EX=1, md_is_div_EX=0 -> md_busy high for 5 cycles. mfhi in ID (md_use_ID=1) stalls for the start cycle plus 5 cycles. md_done pulses once, after which stall=0.
4. Div back-to-back: a div start is followed by a second md_start_EX in the md_done cycle -> md_busy stays high for 10 more cycles and md_err=0.
5. Illegal start: md_start_EX asserted at count 3 of a mult -> count unchanged, md_err=1 persists until reset.
6. Async reset: drop reset mid-div at a non-clock edge -> md_busy=0, md_err=0, stall_cnt=0 immediately. No md_done pulse follows.
